// File: rtl/apb_cpu_master.sv
// Single-outstanding APB3 initiator: turns a valid/ready core request into one
// SETUP/ACCESS transfer and returns a registered response, with a wait-state timeout.
module apb_cpu_master #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              PCLK,
  input  logic              PRESETN,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [31:0]       PWDATA,
  input  logic [31:0]       PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

  state_e              state_q, state_d;
  logic                write_q, write_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                to_q, to_d;
  logic                timeout_hit;

  // A PREADY in the same cycle still wins over the timeout.
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT));

  always_comb begin
    state_d   = state_q;
    write_d   = write_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    to_d      = to_q;
    req_ready = 1'b0;
    PSEL      = 1'b0;
    PENABLE   = 1'b0;
    rsp_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_write ? req_wdata : 32'h0;
          cnt_d   = '0;
          state_d = StSetup;
        end
      end
      StSetup: begin
        PSEL    = 1'b1;
        state_d = StAccess;
      end
      StAccess: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        if (PREADY) begin
          rdata_d = (!write_q && !PSLVERR) ? PRDATA : 32'h0;
          err_d   = PSLVERR;
          to_d    = 1'b0;
          state_d = StResp;
        end else if (timeout_hit) begin
          rdata_d = 32'h0;
          err_d   = 1'b1;
          to_d    = 1'b1;
          state_d = StResp;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StResp: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state_q <= StIdle;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      to_q    <= to_d;
    end
  end

  assign PWRITE      = write_q;
  assign PADDR       = addr_q;
  assign PWDATA      = wdata_q;
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = err_q;
  assign rsp_timeout = to_q;

endmodule
